boot_program_memory: RTL and testbench
======================================

# boot_program_memory

Parametrised boot-time instruction store. It assembles a byte stream from the external ROM reader into words and writes them into on-chip RAM. Once loading finishes, it issues a one-cycle system reset and then serves up to `NUM_READ_PORTS` independent, pipelined, fixed-latency read ports (CPU fetch, data-side ROM reads, GPU tile fetch). Compared with the previous generation, it adds:

- configurable word width, depth and port count;
- endianness selection;
- partial-word flush;
- overflow detection, checksum and software-triggered reload.

## Interface
Parameters:
- `WORD_BYTES`, default 4: bytes per word; legal values 1, 2, 4, 8.
- `DEPTH`, default 2048: words of storage; must be a power of two.
- `NUM_READ_PORTS`, default 2: independent read ports; legal range 1..4.
- `BIG_ENDIAN`, default 0: 0 places the first byte in bits [7:0]; 1 places it in the MSB byte.
- `INIT_FILE`, default "": RAM preload image; "" means no preload.

Ports (`AW` = $clog2(DEPTH*WORD_BYTES), `WW` = 8*WORD_BYTES):
- `clk_in`  in  1  sole clock
- `rst_n_in`  in  1  asynchronous, active-low reset
- `byte_valid_in`  in  1  `byte_in` carries a ROM byte this cycle
- `byte_in`  in  8  ROM byte, sequential from address 0
- `byte_last_in`  in  1  ROM reader finished (may coincide with `byte_valid_in`)
- `reload_in`  in  1  restart loading; honoured only in READY
- `sys_rst_out`  out  1  one-cycle pulse when the image is loaded
- `ready_out`  out  1  high in READY only
- `overflow_out`  out  1  sticky; bytes were discarded beyond capacity
- `words_loaded_out`  out  $clog2(DEPTH+1)  words written by the last load
- `checksum_out`  out  16  mod-2^16 sum of accepted bytes
- `rd_req_in`  in  NUM_READ_PORTS  per-port read request
- `rd_addr_in`  in  NUM_READ_PORTS×AW  per-port byte address
- `rd_data_out`  out  NUM_READ_PORTS×WW  per-port read word
- `rd_valid_out`  out  NUM_READ_PORTS  per-port data valid

## Operation
State machine states are LOAD, FLUSH, RELEASE and READY. Reset enters LOAD.

LOAD:
- Each accepted byte goes into the assembly register at lane `byte_cnt`, where lane = `byte_cnt` if `BIG_ENDIAN`=0, otherwise `WORD_BYTES-1-byte_cnt`.
- Each accepted byte is added to `checksum_out`.
- When lane `WORD_BYTES-1` fills, the word is written at `wr_ptr`, `wr_ptr` increments, and the assembly register clears to 0.
- When `wr_ptr`==`DEPTH`, further bytes are discarded and `overflow_out` is set. Discarded bytes do not affect `checksum_out`.
- `byte_last_in` → FLUSH. A byte valid in the same cycle is processed first.

FLUSH:
- If `byte_cnt`≠0 and capacity remains, write the zero-padded partial word and increment `wr_ptr`.
- Then go to RELEASE.

RELEASE:
- Assert `sys_rst_out` for exactly one cycle.
- Latch `words_loaded_out`=`wr_ptr`.
- Go to READY.

READY:
- `ready_out`=1.
- Each port accepts a request every cycle.
- The word index is `rd_addr_in[AW-1:$clog2(WORD_BYTES)]`; the low address bits are ignored.
- `reload_in` → LOAD. This clears `byte_cnt`, `wr_ptr`, `checksum_out` and `overflow_out`. RAM contents are retained until overwritten.

Outside READY:
- `rd_req_in` is ignored and produces no `rd_valid_out`.
- Reads already in flight complete normally.
- `reload_in` outside READY has no effect.

Reset:
- Reset mid-load restarts in LOAD with all counters cleared.
- RAM contents are not reset.

## Timing
Reset values: `sys_rst_out`=0, `ready_out`=0, `overflow_out`=0, `words_loaded_out`=0, `checksum_out`=0, `rd_valid_out`=0, `rd_data_out`=0.

Write timing:
- The word write is committed one cycle after its final byte is accepted.
- From `byte_last_in` at cycle t: FLUSH is at t+1, RELEASE (with `sys_rst_out`=1) at t+2, and `ready_out`=1 from t+3.

Read timing:
- Fixed 2-cycle latency: a request at cycle t gives `rd_valid_out` and `rd_data_out` at t+2.
- Fully pipelined: one request per port per cycle, with no back-pressure.
- `rd_valid_out` is high for exactly one cycle per accepted request.
- Ports are independent. Same-address reads on several ports return identical data.

## Structure
- Package `boot_mem_pkg`: state enum `boot_state_t`; legality checks on `WORD_BYTES` and `NUM_READ_PORTS` via elaboration-time `$error`.
- Sub-module `boot_ram_bank`: one true dual-port 2-cycle RAM.
  - Instantiate ceil(`NUM_READ_PORTS`/2) banks.
  - Every bank's port A also takes the loader write, broadcast to all banks so the banks stay identical.
  - Ports 2k and 2k+1 map to bank k, ports A and B respectively.
- Valid pipelines use the existing `pipeline` block, one per port (STAGES=2), with their input gated by `ready_out`.

## Test plan
- WORD_BYTES=4, BIG_ENDIAN=0: stream 01 02 03 04 05 06 07 08, then last → word0=0x04030201, word1=0x08070605, `words_loaded_out`=2, `checksum_out`=0x0024, `sys_rst_out` pulses once, exactly 2 cycles after last.
- BIG_ENDIAN=1, bytes AA BB CC, then last → word0=0xAABBCC00 (flushed), `words_loaded_out`=1.
- DEPTH=4, WORD_BYTES=4, 20 bytes of 0x01 → `overflow_out`=1, `words_loaded_out`=4, `checksum_out`=0x0010.
- NUM_READ_PORTS=3 in READY: port0 reads addr 0x0, port1 0x4, port2 0x7 on the same cycle → all valid 2 cycles later with word0, word1, word1. Back-to-back requests over 8 cycles return 8 consecutive valids.
- Requests during LOAD → no `rd_valid_out`. `reload_in` in READY → `ready_out`=0 next cycle, `checksum_out`=0; a read issued the cycle before reload still returns valid.
- Drive `rst_n_in` low mid-load after 3 bytes, then reload 4 bytes → byte lanes restart at 0, `words_loaded_out`=1, all outputs equal their reset values during reset.

Source files
------------

// File: rtl/boot_program_memory_pkg.sv
// Shared types and parameter legality helpers
// for the boot-time instruction store.
package boot_mem_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_FLUSH,
        ST_RELEASE,
        ST_READY
    } boot_state_t;

    function automatic bit word_bytes_ok(input int wb);
        return (wb == 1) || (wb == 2) || (wb == 4) || (wb == 8);
    endfunction

    function automatic bit ports_ok(input int np);
        return (np >= 1) && (np <= 4);
    endfunction

    function automatic bit depth_ok(input int d);
        return (d >= 2) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/boot_program_memory_if.sv
// Multi-port read bus between fetch clients
// and the boot program memory.
interface boot_program_memory_if #(
    parameter int NP = 2,
    parameter int AW = 13,
    parameter int WW = 32
);
    logic [NP-1:0]    rd_req_in;
    logic [NP*AW-1:0] rd_addr_in;
    logic [NP*WW-1:0] rd_data_out;
    logic [NP-1:0]    rd_valid_out;

    modport master (
        output rd_req_in,
        output rd_addr_in,
        input  rd_data_out,
        input  rd_valid_out
    );

    modport slave (
        input  rd_req_in,
        input  rd_addr_in,
        output rd_data_out,
        output rd_valid_out
    );
endinterface

// File: rtl/boot_program_memory_bank.sv
// True dual-port RAM bank with two-cycle read latency;
// port A also carries the loader write.
module boot_ram_bank #(
  parameter int    DEPTH     = 2048,
  parameter int    WW        = 32,
  parameter int    IW        = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          en_a_i,
  input  logic          we_a_i,
  input  logic [IW-1:0] addr_a_i,
  input  logic [WW-1:0] wdata_a_i,
  output logic [WW-1:0] rdata_a_o,
  input  logic          en_b_i,
  input  logic [IW-1:0] addr_b_i,
  output logic [WW-1:0] rdata_b_o
);
  logic [WW-1:0] mem [DEPTH];
  logic [WW-1:0] a1_q, a2_q, b1_q, b2_q;

  always_ff @(posedge clk_i) begin
    if (en_a_i && we_a_i)
      mem[addr_a_i] <= wdata_a_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a1_q <= '0;
      a2_q <= '0;
      b1_q <= '0;
      b2_q <= '0;
    end else begin
      if (en_a_i && !we_a_i)
        a1_q <= mem[addr_a_i];
      if (en_b_i)
        b1_q <= mem[addr_b_i];
      a2_q <= a1_q;
      b2_q <= b1_q;
    end
  end

  assign rdata_a_o = a2_q;
  assign rdata_b_o = b2_q;
endmodule

// File: rtl/pipeline.sv
// Generic reset-to-zero delay line used to align
// read-valid flags with RAM output latency.
module pipeline #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] stage_q [STAGES];

    // shift register, cleared on reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[STAGES-1];
endmodule

// File: rtl/boot_program_memory.sv
// Boot loader: packs ROM bytes into words, pulses a system
// reset, then serves pipelined multi-port reads.
module boot_program_memory
    import boot_mem_pkg::*;
#(
    parameter int    WORD_BYTES     = 4,
    parameter int    DEPTH          = 2048,
    parameter int    NUM_READ_PORTS = 2,
    parameter bit    BIG_ENDIAN     = 1'b0,
    parameter string INIT_FILE      = ""
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       byte_valid_in,
    input  logic [7:0]                 byte_in,
    input  logic                       byte_last_in,
    input  logic                       reload_in,
    output logic                       sys_rst_out,
    output logic                       ready_out,
    output logic                       overflow_out,
    output logic [$clog2(DEPTH+1)-1:0] words_loaded_out,
    output logic [15:0]                checksum_out,
    boot_program_memory_if.slave       rd
);
    localparam int WW  = 8 * WORD_BYTES;
    localparam int IW  = $clog2(DEPTH);
    localparam int LB  = $clog2(WORD_BYTES);
    localparam int AW  = IW + LB;
    localparam int PW  = $clog2(DEPTH + 1);
    localparam int BCW = (WORD_BYTES > 1) ? LB : 1;
    localparam int NB  = (NUM_READ_PORTS + 1) / 2;

    if (!word_bytes_ok(WORD_BYTES)) begin : g_bad_wb
        $error("WORD_BYTES must be 1, 2, 4 or 8");
    end
    if (!ports_ok(NUM_READ_PORTS)) begin : g_bad_np
        $error("NUM_READ_PORTS must be 1..4");
    end
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end

    boot_state_t    state_q, state_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [WW-1:0]  asm_q, asm_d;
    logic [15:0]    csum_q, csum_d;
    logic           ovf_q, ovf_d;
    logic [PW-1:0]  wl_q, wl_d;
    logic           we_q, we_d;
    logic [IW-1:0]  waddr_q, waddr_d;
    logic [WW-1:0]  wdata_q, wdata_d;
    logic [BCW-1:0] lane;
    logic           has_room;

    assign lane = BIG_ENDIAN ? (BCW'(WORD_BYTES - 1) - byte_cnt_q)
                             : byte_cnt_q;
    assign has_room = (wr_ptr_q != PW'(DEPTH));

    // state and loader datapath registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_LOAD;
            byte_cnt_q <= '0;
            wr_ptr_q   <= '0;
            asm_q      <= '0;
            csum_q     <= '0;
            ovf_q      <= 1'b0;
            wl_q       <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            asm_q      <= asm_d;
            csum_q     <= csum_d;
            ovf_q      <= ovf_d;
            wl_q       <= wl_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    // next state; writes are staged one cycle in we/waddr/wdata
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        asm_d      = asm_q;
        csum_d     = csum_q;
        ovf_d      = ovf_q;
        wl_d       = wl_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        unique case (state_q)
            ST_LOAD: begin
                if (byte_valid_in) begin
                    if (has_room) begin
                        asm_d[{lane, 3'b000} +: 8] = byte_in;
                        csum_d = csum_q + {8'h00, byte_in};
                        if (byte_cnt_q == BCW'(WORD_BYTES - 1)) begin
                            we_d       = 1'b1;
                            waddr_d    = wr_ptr_q[IW-1:0];
                            wdata_d    = asm_d;
                            asm_d      = '0;
                            byte_cnt_d = '0;
                            wr_ptr_d   = wr_ptr_q + PW'(1);
                        end else begin
                            byte_cnt_d = byte_cnt_q + BCW'(1);
                        end
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (byte_last_in) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if ((byte_cnt_q != '0) && has_room) begin
                    we_d     = 1'b1;
                    waddr_d  = wr_ptr_q[IW-1:0];
                    wdata_d  = asm_q;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
                byte_cnt_d = '0;
                asm_d      = '0;
                state_d    = ST_RELEASE;
            end
            ST_RELEASE: begin
                wl_d    = wr_ptr_q;
                state_d = ST_READY;
            end
            ST_READY: begin
                if (reload_in) begin
                    state_d    = ST_LOAD;
                    byte_cnt_d = '0;
                    wr_ptr_d   = '0;
                    asm_d      = '0;
                    csum_d     = '0;
                    ovf_d      = 1'b0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    assign sys_rst_out      = (state_q == ST_RELEASE);
    assign ready_out        = (state_q == ST_READY);
    assign overflow_out     = ovf_q;
    assign words_loaded_out = wl_q;
    assign checksum_out     = csum_q;

    logic [NUM_READ_PORTS-1:0] rd_go;
    logic [NUM_READ_PORTS-1:0] unused_addr;

    assign rd_go = rd.rd_req_in & {NUM_READ_PORTS{ready_out}};

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
        assign unused_addr[p] = ^rd.rd_addr_in[p*AW +: AW];
        pipeline #(.STAGES(2), .WIDTH(1)) u_vld (
            .clk_i   (clk_in),
            .rst_n_i (rst_n_in),
            .d_i     (rd_go[p]),
            .q_o     (rd.rd_valid_out[p])
        );
    end

    // every bank sees the loader write so all copies match
    for (genvar k = 0; k < NB; k++) begin : g_bank
        logic          en_b;
        logic [IW-1:0] addr_a, addr_b;
        logic [WW-1:0] rdata_b;

        assign addr_a = we_q ? waddr_q
                             : rd.rd_addr_in[2*k*AW+LB +: IW];

        if (2*k+1 < NUM_READ_PORTS) begin : g_b
            assign en_b   = rd_go[2*k+1];
            assign addr_b = rd.rd_addr_in[(2*k+1)*AW+LB +: IW];
            assign rd.rd_data_out[(2*k+1)*WW +: WW] = rdata_b;
        end else begin : g_nob
            logic [WW-1:0] unused_rdata_b;
            assign en_b           = 1'b0;
            assign addr_b         = '0;
            assign unused_rdata_b = rdata_b;
        end

        boot_ram_bank #(
            .DEPTH     (DEPTH),
            .WW        (WW),
            .IW        (IW),
            .INIT_FILE (INIT_FILE)
        ) u_bank (
            .clk_i     (clk_in),
            .rst_n_i   (rst_n_in),
            .en_a_i    (we_q | rd_go[2*k]),
            .we_a_i    (we_q),
            .addr_a_i  (addr_a),
            .wdata_a_i (wdata_q),
            .rdata_a_o (rd.rd_data_out[2*k*WW +: WW]),
            .en_b_i    (en_b),
            .addr_b_i  (addr_b),
            .rdata_b_o (rdata_b)
        );
    end
endmodule

// File: tb/tb_boot_program_memory.sv
// Directed bench: little-endian 3-port instance and a
// big-endian 4-word instance for flush/overflow.
module tb_boot_program_memory;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_bv, a_last, a_rl, a_srst, a_rdy, a_ovf;
    logic [7:0] a_b;
    logic [4:0] a_wl;
    logic [15:0] a_cs;
    logic       b_bv, b_last, b_rl, b_srst, b_rdy, b_ovf;
    logic [7:0] b_b;
    logic [2:0] b_wl;
    logic [15:0] b_cs;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] W0 = 32'h04030201;
    localparam logic [31:0] W1 = 32'h08070605;

    boot_program_memory_if #(.NP(3), .AW(6), .WW(32)) ra ();
    boot_program_memory_if #(.NP(1), .AW(4), .WW(32)) rb ();

    boot_program_memory #(
        .WORD_BYTES(4), .DEPTH(16), .NUM_READ_PORTS(3), .BIG_ENDIAN(1'b0)
    ) dut_a (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .byte_valid_in    (a_bv),
        .byte_in          (a_b),
        .byte_last_in     (a_last),
        .reload_in        (a_rl),
        .sys_rst_out      (a_srst),
        .ready_out        (a_rdy),
        .overflow_out     (a_ovf),
        .words_loaded_out (a_wl),
        .checksum_out     (a_cs),
        .rd               (ra)
    );

    boot_program_memory #(
        .WORD_BYTES(4), .DEPTH(4), .NUM_READ_PORTS(1), .BIG_ENDIAN(1'b1)
    ) dut_b (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .byte_valid_in    (b_bv),
        .byte_in          (b_b),
        .byte_last_in     (b_last),
        .reload_in        (b_rl),
        .sys_rst_out      (b_srst),
        .ready_out        (b_rdy),
        .overflow_out     (b_ovf),
        .words_loaded_out (b_wl),
        .checksum_out     (b_cs),
        .rd               (rb)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic a_reset_vals(input string tag);
        chk({tag, "_sys"}, a_srst, 0);
        chk({tag, "_rdy"}, a_rdy, 0);
        chk({tag, "_ovf"}, a_ovf, 0);
        chk({tag, "_wl"}, a_wl, 0);
        chk({tag, "_cs"}, a_cs, 0);
        chk({tag, "_val"}, ra.rd_valid_out, 0);
        chk({tag, "_dat"}, ra.rd_data_out[63:0], 0);
        chk({tag, "_dat2"}, ra.rd_data_out[95:64], 0);
    endtask

    initial begin
        rst_n = 1'b0;
        {a_bv, a_last, a_rl, a_b} = '0;
        {b_bv, b_last, b_rl, b_b} = '0;
        ra.rd_req_in = '0;
        ra.rd_addr_in = '0;
        rb.rd_req_in = '0;
        rb.rd_addr_in = '0;
        repeat (2) @(negedge clk);
        a_reset_vals("rst");
        chk("rst_b_rdy", b_rdy, 0);
        chk("rst_b_wl", b_wl, 0);
        rst_n = 1'b1;

        for (int i = 1; i <= 8; i++) begin
            a_bv = 1'b1;
            a_b = 8'(i);
            ra.rd_req_in = '1;
            @(negedge clk);
            chk("load_noval", ra.rd_valid_out, 0);
        end
        a_bv = 1'b0;
        a_last = 1'b1;
        @(negedge clk);
        a_last = 1'b0;
        chk("flush_sys", a_srst, 0);
        chk("flush_rdy", a_rdy, 0);
        @(negedge clk);
        chk("rel_sys", a_srst, 1);
        chk("rel_rdy", a_rdy, 0);
        chk("rel_val", ra.rd_valid_out, 0);
        ra.rd_req_in = '0;
        @(negedge clk);
        chk("rdy_sys", a_srst, 0);
        chk("rdy_rdy", a_rdy, 1);
        chk("rdy_wl", a_wl, 2);
        chk("rdy_cs", a_cs, 16'h0024);
        chk("rdy_val", ra.rd_valid_out, 0);
        @(negedge clk);
        chk("rdy_val2", ra.rd_valid_out, 0);

        ra.rd_req_in = 3'b111;
        ra.rd_addr_in = {6'd7, 6'd4, 6'd0};
        @(negedge clk);
        ra.rd_req_in = '0;
        chk("rd_lat1", ra.rd_valid_out, 0);
        @(negedge clk);
        chk("rd_val", ra.rd_valid_out, 3'b111);
        chk("rd_p0", ra.rd_data_out[31:0], W0);
        chk("rd_p1", ra.rd_data_out[63:32], W1);
        chk("rd_p2", ra.rd_data_out[95:64], W1);
        @(negedge clk);
        chk("rd_once", ra.rd_valid_out, 0);

        for (int k = 0; k < 10; k++) begin
            if (k >= 2) begin
                chk("b2b_val", ra.rd_valid_out, 3'b111);
                chk("b2b_p0", ra.rd_data_out[31:0], k[0] ? W1 : W0);
            end
            ra.rd_req_in = (k < 8) ? 3'b111 : 3'b000;
            ra.rd_addr_in = {6'd7, 6'd4, (k[0] ? 6'd4 : 6'd0)};
            @(negedge clk);
        end
        chk("b2b_end", ra.rd_valid_out, 0);

        ra.rd_req_in = 3'b001;
        ra.rd_addr_in = {6'd0, 6'd0, 6'd4};
        @(negedge clk);
        ra.rd_req_in = '0;
        a_rl = 1'b1;
        chk("rl_pre_rdy", a_rdy, 1);
        @(negedge clk);
        a_rl = 1'b0;
        chk("rl_rdy", a_rdy, 0);
        chk("rl_cs", a_cs, 0);
        chk("rl_val", ra.rd_valid_out, 3'b001);
        chk("rl_dat", ra.rd_data_out[31:0], W1);

        a_bv = 1'b1;
        a_b = 8'h11;
        @(negedge clk);
        a_b = 8'h22;
        @(negedge clk);
        a_b = 8'h33;
        @(negedge clk);
        a_bv = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        a_reset_vals("mid");
        rst_n = 1'b1;
        a_bv = 1'b1;
        a_b = 8'h44;
        @(negedge clk);
        a_b = 8'h55;
        @(negedge clk);
        a_b = 8'h66;
        @(negedge clk);
        a_b = 8'h77;
        @(negedge clk);
        a_bv = 1'b0;
        a_last = 1'b1;
        @(negedge clk);
        a_last = 1'b0;
        @(negedge clk);
        chk("rs_sys", a_srst, 1);
        @(negedge clk);
        chk("rs_rdy", a_rdy, 1);
        chk("rs_wl", a_wl, 1);
        chk("rs_cs", a_cs, 16'h0176);
        ra.rd_req_in = 3'b010;
        ra.rd_addr_in = {6'd0, 6'd1, 6'd0};
        @(negedge clk);
        ra.rd_req_in = '0;
        @(negedge clk);
        chk("rs_val", ra.rd_valid_out, 3'b010);
        chk("rs_dat", ra.rd_data_out[63:32], 32'h77665544);

        b_bv = 1'b1;
        b_b = 8'hAA;
        @(negedge clk);
        b_b = 8'hBB;
        @(negedge clk);
        b_b = 8'hCC;
        @(negedge clk);
        b_bv = 1'b0;
        b_last = 1'b1;
        @(negedge clk);
        b_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("be_rdy", b_rdy, 1);
        chk("be_wl", b_wl, 1);
        chk("be_cs", b_cs, 16'h0231);
        chk("be_ovf", b_ovf, 0);
        rb.rd_req_in = 1'b1;
        rb.rd_addr_in = 4'd0;
        @(negedge clk);
        rb.rd_req_in = 1'b0;
        @(negedge clk);
        chk("be_val", rb.rd_valid_out, 1);
        chk("be_dat", rb.rd_data_out, 32'hAABBCC00);

        b_rl = 1'b1;
        @(negedge clk);
        b_rl = 1'b0;
        chk("brl_rdy", b_rdy, 0);
        chk("brl_cs", b_cs, 0);
        for (int i = 0; i < 20; i++) begin
            b_bv = 1'b1;
            b_b = 8'h01;
            @(negedge clk);
            if (i == 15) chk("ov_full", b_ovf, 0);
        end
        b_bv = 1'b0;
        chk("ov_set", b_ovf, 1);
        b_last = 1'b1;
        @(negedge clk);
        b_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ov_rdy", b_rdy, 1);
        chk("ov_wl", b_wl, 4);
        chk("ov_cs", b_cs, 16'h0010);
        chk("ov_sticky", b_ovf, 1);
        rb.rd_req_in = 1'b1;
        rb.rd_addr_in = 4'd12;
        @(negedge clk);
        rb.rd_addr_in = 4'd0;
        @(negedge clk);
        rb.rd_req_in = 1'b0;
        chk("ov_val3", rb.rd_valid_out, 1);
        chk("ov_w3", rb.rd_data_out, 32'h01010101);
        @(negedge clk);
        chk("ov_val0", rb.rd_valid_out, 1);
        chk("ov_w0", rb.rd_data_out, 32'h01010101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
